// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES-128 key-schedule types, S-box and round constants.
package aes_key_sched_ctrl_pkg;

   typedef logic [127:0] aes_key_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for rounds 1..10; other indices never reach the datapath.
   function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
      logic [7:0] rc;
      rc = 8'h00;
      unique case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic aes_word_t sub_word(input aes_word_t w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_key_round.sv
// One combinational AES-128 key-expansion round: RotWord, SubWord, Rcon, XOR chain.
module aes_key_sched_ctrl_key_round
   import aes_key_sched_ctrl_pkg::*;
(
   input  logic [127:0] i_prev,
   input  logic [7:0]   i_rcon,
   output logic [127:0] o_next
);

   aes_word_t w_rot;
   aes_word_t w_temp;
   aes_word_t w_w4;
   aes_word_t w_w5;
   aes_word_t w_w6;
   aes_word_t w_w7;

   assign w_rot  = {i_prev[23:0], i_prev[31:24]};
   assign w_temp = sub_word(w_rot) ^ {i_rcon, 24'h000000};
   assign w_w4   = i_prev[127:96] ^ w_temp;
   assign w_w5   = i_prev[95:64]  ^ w_w4;
   assign w_w6   = i_prev[63:32]  ^ w_w5;
   assign w_w7   = i_prev[31:0]   ^ w_w6;
   assign o_next = {w_w4, w_w5, w_w6, w_w7};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: accepts a key, expands one round per cycle into an
// 11-entry round-key file and serves entries through a registered read port.
module aes_key_sched_ctrl
   import aes_key_sched_ctrl_pkg::*;
#(
   parameter int unsigned N = 128,
   parameter int unsigned R = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] key_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic         clear_i,
   input  logic [3:0]   rk_idx_i,
   output logic [N-1:0] rk_o,
   output logic         keys_valid_o,
   output logic         busy_o,
   output logic         done_o
);

   state_e       r_state;
   state_e       w_state_nxt;
   logic [3:0]   r_round_cnt;
   logic [3:0]   w_round_cnt_nxt;
   logic         r_keys_valid;
   logic         w_keys_valid_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic         w_load;
   logic         w_write;
   aes_key_t     r_cur;
   aes_key_t     w_next_key;
   logic [N-1:0] r_rk [0:R];
   logic [N-1:0] r_rk_o;

   aes_key_sched_ctrl_key_round u_key_round (
      .i_prev (r_cur),
      .i_rcon (rcon_byte(r_round_cnt)),
      .o_next (w_next_key)
   );

   assign key_ready_o  = (r_state != StExpand) && !clear_i;
   assign busy_o       = (r_state == StExpand);
   assign keys_valid_o = r_keys_valid;
   assign done_o       = r_done;
   assign rk_o         = r_rk_o;

   always_comb begin
      w_state_nxt      = r_state;
      w_round_cnt_nxt  = r_round_cnt;
      w_keys_valid_nxt = r_keys_valid;
      w_done_nxt       = 1'b0;
      w_load           = 1'b0;
      w_write          = 1'b0;
      // clear wins over a same-cycle handshake; the offered key is dropped
      if (clear_i) begin
         w_state_nxt      = StIdle;
         w_round_cnt_nxt  = 4'd0;
         w_keys_valid_nxt = 1'b0;
      end else begin
         unique case (r_state)
            StIdle, StReady: begin
               if (key_valid_i) begin
                  w_load           = 1'b1;
                  w_state_nxt      = StExpand;
                  w_round_cnt_nxt  = 4'd1;
                  w_keys_valid_nxt = 1'b0;
               end
            end
            StExpand: begin
               w_write = 1'b1;
               if (32'(r_round_cnt) == R) begin
                  w_state_nxt      = StReady;
                  w_round_cnt_nxt  = 4'd0;
                  w_keys_valid_nxt = 1'b1;
                  w_done_nxt       = 1'b1;
               end else begin
                  w_round_cnt_nxt = r_round_cnt + 4'd1;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_round_cnt  <= 4'd0;
         r_keys_valid <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_round_cnt  <= w_round_cnt_nxt;
         r_keys_valid <= w_keys_valid_nxt;
         r_done       <= w_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur  <= '0;
         r_rk_o <= '0;
         for (int unsigned i = 0; i <= R; i++) begin
            r_rk[i] <= '0;
         end
      end else begin
         if (w_load) begin
            r_rk[0] <= key_i;
            r_cur   <= key_i;
         end else if (w_write) begin
            r_rk[r_round_cnt] <= w_next_key;
            r_cur             <= w_next_key;
         end
         r_rk_o <= (32'(rk_idx_i) <= R) ? r_rk[rk_idx_i] : '0;
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against a word-level FIPS-197 key-expansion model.
module tb_aes_key_sched_ctrl;

   logic         clk;
   logic         rst_n;
   logic [127:0] key_i;
   logic         key_valid_i;
   logic         key_ready_o;
   logic         clear_i;
   logic [3:0]   rk_idx_i;
   logic [127:0] rk_o;
   logic         keys_valid_o;
   logic         busy_o;
   logic         done_o;

   int n_tests;
   int n_fail;

   logic [7:0]   sb [256];
   logic [127:0] ref_rk [11];

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic [127:0] rk;
   } vec_t;

   vec_t vecs [10];

   aes_key_sched_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_i        (key_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .clear_i      (clear_i),
      .rk_idx_i     (rk_idx_i),
      .rk_o         (rk_o),
      .keys_valid_o (keys_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = {aa[6:0], 1'b0};
         if (hi) aa = aa ^ 8'h1b;
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box from the GF(2^8) inverse and the affine map, independent of any table
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) begin
         a   = 8'(i);
         inv = 8'h00;
         if (i != 0) begin
            for (int j = 1; j < 256; j++) begin
               if (gmul(a, 8'(j)) == 8'h01) inv = 8'(j);
            end
         end
         sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic ref_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_read(input int idx);
      return (idx <= 10) ? ref_rk[idx] : 128'h0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a key and returns just after the accepting edge.
   task automatic load_key(input logic [127:0] k);
      bit acc;
      acc         = 1'b0;
      key_i       = k;
      key_valid_i = 1'b1;
      for (int c = 0; c < 30 && !acc; c++) begin
         #1;
         acc = key_ready_o;
         tick();
      end
      key_valid_i = 1'b0;
      if (!acc) chk("load_accept", 128'(acc), 128'h1);
   endtask

   // Counts edges from the handshake until done_o is seen, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (done_o) begin
            cycles = c;
            break;
         end
      end
   endtask

   task automatic read_rk(input int idx, output logic [127:0] v);
      rk_idx_i = 4'(idx);
      tick();
      v = rk_o;
   endtask

   task automatic expand(input logic [127:0] k, input string name);
      int cyc;
      ref_expand(k);
      load_key(k);
      wait_done(cyc);
      chk({name, "_latency"}, 128'(cyc), 128'd10);
   endtask

   initial begin
      logic [127:0] v;
      logic [127:0] cur_key;
      logic [127:0] ka;
      logic [127:0] kb;
      int           cyc;
      int           pulses;
      int           idx;

      n_tests     = 0;
      n_fail      = 0;
      key_i       = '0;
      key_valid_i = 1'b0;
      clear_i     = 1'b0;
      rk_idx_i    = 4'd0;
      rst_n       = 1'b0;
      build_sbox();

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,
                  128'h2b7e151628aed2a6abf7158809cf4f3c};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,
                  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd2,
                  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd11, 128'h0};
      vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd15, 128'h0};
      vecs[6] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd1,
                  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
      vecs[7] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd10,
                  128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[8] = '{128'h0, 4'd1, 128'h62636363626363636263636362636363};
      vecs[9] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      // Reset
      repeat (3) tick();
      #2;
      rst_n = 1'b1;
      tick();
      chk("rst_rk_o", rk_o, 128'h0);
      chk("rst_keys_valid", 128'(keys_valid_o), 128'h0);
      chk("rst_busy", 128'(busy_o), 128'h0);
      chk("rst_done", 128'(done_o), 128'h0);
      chk("rst_ready", 128'(key_ready_o), 128'h1);
      read_rk(5, v);
      chk("rst_rkfile", v, 128'h0);

      // FIPS-197 key: latency and done pulse width
      ref_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_busy", 128'(busy_o), 128'h1);
      chk("fips_ready_low", 128'(key_ready_o), 128'h0);
      wait_done(cyc);
      chk("fips_latency", 128'(cyc), 128'd10);
      chk("fips_valid", 128'(keys_valid_o), 128'h1);
      tick();
      chk("fips_done_pulse", 128'(done_o), 128'h0);
      cur_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

      // Read sweep against the model
      for (int i = 0; i < 16; i++) begin
         read_rk(i, v);
         chk($sformatf("sweep_idx%0d", i), v, ref_read(i));
      end

      // Table of known-answer vectors
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].key !== cur_key) begin
            expand(vecs[i].key, "tbl");
            cur_key = vecs[i].key;
         end
         read_rk(int'(vecs[i].idx), v);
         chk($sformatf("tbl_vec%0d", i), v, vecs[i].rk);
      end

      // Randomised keys against the model
      for (int n = 0; n < 12; n++) begin
         ka = {$urandom, $urandom, $urandom, $urandom};
         expand(ka, "rnd");
         for (int m = 0; m < 4; m++) begin
            idx = int'($urandom_range(0, 15));
            read_rk(idx, v);
            chk($sformatf("rnd%0d_idx%0d", n, idx), v, ref_read(idx));
         end
      end

      // Key offered mid-expansion is held off until READY
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      ref_expand(ka);
      load_key(ka);
      repeat (5) tick();
      key_i       = kb;
      key_valid_i = 1'b1;
      rk_idx_i    = 4'd10;
      #1;
      chk("mid_ready_low", 128'(key_ready_o), 128'h0);
      wait_done(cyc);
      chk("mid_done_seen", 128'(done_o), 128'h1);
      chk("mid_valid_a", 128'(keys_valid_o), 128'h1);
      tick();
      key_valid_i = 1'b0;
      chk("mid_valid_drop", 128'(keys_valid_o), 128'h0);
      chk("mid_busy_b", 128'(busy_o), 128'h1);
      chk("mid_rk10_a", rk_o, ref_rk[10]);
      ref_expand(kb);
      wait_done(cyc);
      chk("mid_latency_b", 128'(cyc), 128'd10);
      read_rk(10, v);
      chk("mid_rk10_b", v, ref_rk[10]);
      read_rk(0, v);
      chk("mid_rk0_b", v, kb);

      // clear_i together with a key at round 7
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      load_key(ka);
      repeat (6) tick();
      clear_i     = 1'b1;
      key_i       = kb;
      key_valid_i = 1'b1;
      #1;
      chk("clr_ready_low", 128'(key_ready_o), 128'h0);
      tick();
      clear_i     = 1'b0;
      key_valid_i = 1'b0;
      chk("clr_busy", 128'(busy_o), 128'h0);
      chk("clr_valid", 128'(keys_valid_o), 128'h0);
      chk("clr_done", 128'(done_o), 128'h0);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done_o || busy_o) pulses++;
      end
      chk("clr_no_activity", 128'(pulses), 128'h0);
      chk("clr_idle_ready", 128'(key_ready_o), 128'h1);
      read_rk(0, v);
      chk("clr_key_dropped", v, ka);

      // Asynchronous reset between edges mid-expansion
      load_key({$urandom, $urandom, $urandom, $urandom});
      rk_idx_i = 4'd0;
      repeat (4) tick();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_rk_o", rk_o, 128'h0);
      chk("arst_busy", 128'(busy_o), 128'h0);
      chk("arst_valid", 128'(keys_valid_o), 128'h0);
      chk("arst_done", 128'(done_o), 128'h0);
      chk("arst_ready", 128'(key_ready_o), 128'h1);
      #1;
      rst_n = 1'b1;
      tick();
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c, "arst");
      read_rk(1, v);
      chk("arst_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(10, v);
      chk("arst_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
